sm_step_ctrl: RTL

- Downstream stage of the stepper-motor pulse generator.
- Consumes the periodic drv_step strobe and runs a move of a commanded length and direction. It drives the physical STEP/DIR/ENABLE lines to the SM driver IC, with a guaranteed DIR setup time and a guaranteed STEP pulse width.
- Tracks absolute position, stops on a limit switch, and reports move completion.

---
 rtl/sm_step_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sm_step_ctrl.sv
// sm_step_ctrl: turns periodic drv_step strobes into a commanded move on the
// STEP/DIR/ENABLE lines of a stepper driver IC. Guarantees DIR setup time
// before the first step and a fixed STEP high time, tracks absolute position,
// stops on the limit switch in the direction of travel and reports completion.
//
// Command handshake: move_start is a single-cycle strobe, honoured only while
// busy is low; there is no ready signal, a strobe arriving while busy is
// dropped. drv_step is a request strobe accepted only in WAIT_STEP; requests
// arriving in any other state are dropped, never queued.
module sm_step_ctrl #(
  parameter int POS_W     = 24,
  parameter int PULSE_W   = 5,
  parameter int DIR_SETUP = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_step,
  input  logic             move_start,
  input  logic             move_dir,
  input  logic [POS_W-1:0] move_steps,
  input  logic             abort,
  input  logic             lim_fwd,
  input  logic             lim_rev,
  input  logic             home_zero,
  output logic             sm_step,
  output logic             sm_dir,
  output logic             sm_enable,
  output logic             busy,
  output logic             done,
  output logic             fault_limit,
  output logic             aborted,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] steps_left
);

  // One down-counter serves both the DIR setup hold and the STEP high time.
  localparam int CNT_MAX = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    WAIT_STEP = 2'd2,
    STEP_HI   = 2'd3
  } state_t;

  // Visible to bound checkers as sm_step_ctrl.state.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lim_hit;

  // Only the limit switch in the current direction of travel can stop a move.
  assign lim_hit = sm_dir ? lim_fwd : lim_rev;

  // Move sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sm_step     <= 1'b0;
      sm_dir      <= 1'b0;
      sm_enable   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault_limit <= 1'b0;
      aborted     <= 1'b0;
      position    <= '0;
      steps_left  <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort wins over everything, truncating any STEP pulse in flight.
        state     <= IDLE;
        sm_step   <= 1'b0;
        busy      <= 1'b0;
        sm_enable <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (home_zero) position <= '0;
            if (move_start) begin
              fault_limit <= 1'b0;
              aborted     <= 1'b0;
              if (move_steps != '0) begin
                steps_left <= move_steps;
                sm_dir     <= move_dir;
                busy       <= 1'b1;
                sm_enable  <= 1'b1;
                cnt        <= CNT_W'(DIR_SETUP - 1);
                state      <= SETUP;
              end else begin
                done <= 1'b1;
              end
            end
          end
          SETUP: begin
            if (cnt == '0) state <= WAIT_STEP;
            else           cnt   <= cnt - 1'b1;
          end
          WAIT_STEP: begin
            if (drv_step) begin
              if (lim_hit) begin
                fault_limit <= 1'b1;
                done        <= 1'b1;
                busy        <= 1'b0;
                sm_enable   <= 1'b0;
                state       <= IDLE;
              end else begin
                sm_step  <= 1'b1;
                position <= sm_dir ? position + 1'b1 : position - 1'b1;
                // Nonzero on entry to every WAIT_STEP, so this cannot wrap.
                if (steps_left != '0) steps_left <= steps_left - 1'b1;
                cnt      <= CNT_W'(PULSE_W - 1);
                state    <= STEP_HI;
              end
            end
          end
          STEP_HI: begin
            if (cnt == '0) begin
              sm_step <= 1'b0;
              if (steps_left == '0) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                sm_enable <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= WAIT_STEP;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
